// File: rtl/riscv_pkg.sv
// Shared RISC-V core widths and register-file types.
package riscv_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned NUM_REGS       = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned ADDR_W         = REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           reg_data_t;

    // x0 is architecturally hardwired to zero and has no storage.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == reg_addr_t'(0);
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback connection to the integer register file.
interface register_file_if;
    import riscv_pkg::*;

    logic      clk;
    logic      rst_n;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    reg_addr_t rd_addr;
    reg_data_t data_in;
    logic      write_en;
    reg_data_t data_out_rs1;
    reg_data_t data_out_rs2;

    modport register_file (
        input  clk, rst_n, rs1_addr, rs2_addr, rd_addr, data_in, write_en,
        output data_out_rs1, data_out_rs2
    );

    modport driver (
        output clk, rst_n, rs1_addr, rs2_addr, rd_addr, data_in, write_en,
        input  data_out_rs1, data_out_rs2
    );

    modport monitor (
        input clk, rst_n, rs1_addr, rs2_addr, rd_addr, data_in, write_en,
        input data_out_rs1, data_out_rs2
    );

endinterface

// File: rtl/register_file.sv
// 32 x XLEN integer register file: two combinational read ports, one
// synchronous write port, x0 reads as zero, optional write-through bypass.
module register_file
    import riscv_pkg::*;
#(
    parameter bit WR_BYPASS = 1'b1
) (
    register_file_if.register_file rf_if
);

    reg_data_t regs [1:NUM_REGS-1];

    always_ff @(posedge rf_if.clk or negedge rf_if.rst_n) begin
        if (!rf_if.rst_n) begin
            for (int i = 1; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (rf_if.write_en && !is_x0(rf_if.rd_addr)) begin
            regs[rf_if.rd_addr] <= rf_if.data_in;
        end
    end

    // Shared by both read ports; bypass is gated by rst_n so reset reads stay zero.
    function automatic reg_data_t read_mux(
        input reg_addr_t addr,
        input reg_data_t stored,
        input logic      rst_n,
        input logic      wen,
        input reg_addr_t waddr,
        input reg_data_t wdata
    );
        reg_data_t val;
        val = '0;
        if (!is_x0(addr)) begin
            val = stored;
            if (WR_BYPASS && rst_n && wen && (waddr == addr)) begin
                val = wdata;
            end
        end
        return val;
    endfunction

    reg_data_t rs1_stored;
    reg_data_t rs2_stored;

    // The x0 lookup is masked inside read_mux, so the index is only valid when used.
    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        if (!is_x0(rf_if.rs1_addr)) rs1_stored = regs[rf_if.rs1_addr];
        if (!is_x0(rf_if.rs2_addr)) rs2_stored = regs[rf_if.rs2_addr];
    end

    always_comb begin
        rf_if.data_out_rs1 = read_mux(rf_if.rs1_addr, rs1_stored, rf_if.rst_n,
                                      rf_if.write_en, rf_if.rd_addr, rf_if.data_in);
        rf_if.data_out_rs2 = read_mux(rf_if.rs2_addr, rs2_stored, rf_if.rst_n,
                                      rf_if.write_en, rf_if.rd_addr, rf_if.data_in);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    import riscv_pkg::*;

    register_file_if rf_if ();

    register_file #(.WR_BYPASS(1'b1)) dut (.rf_if(rf_if.register_file));

    int total = 0;
    int bad   = 0;

    initial rf_if.clk = 1'b0;
    always #5 rf_if.clk = ~rf_if.clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Write strobe must never be raised while reset is asserted.
    always @(posedge rf_if.clk) begin
        if (!rf_if.rst_n) begin
            total++;
            assert (rf_if.write_en === 1'b0) else begin
                bad++;
                $error("FAIL wen_in_reset observed=%b expected=0", rf_if.write_en);
            end
        end
    end

    task automatic do_write(input reg_addr_t a, input reg_data_t d);
        @(negedge rf_if.clk);
        rf_if.write_en = 1'b1;
        rf_if.rd_addr  = a;
        rf_if.data_in  = d;
        @(posedge rf_if.clk);
        #1;
        rf_if.write_en = 1'b0;
    endtask

    task automatic read2(input reg_addr_t a1, input reg_addr_t a2);
        rf_if.rs1_addr = a1;
        rf_if.rs2_addr = a2;
        #1;
    endtask

    initial begin
        rf_if.rst_n    = 1'b0;
        rf_if.write_en = 1'b0;
        rf_if.rd_addr  = '0;
        rf_if.data_in  = '0;
        rf_if.rs1_addr = 5'd1;
        rf_if.rs2_addr = 5'd31;
        #50;
        check("reset_hold_rs1", rf_if.data_out_rs1, 32'h0);
        check("reset_hold_rs2", rf_if.data_out_rs2, 32'h0);
        #50;
        @(negedge rf_if.clk);
        rf_if.rst_n = 1'b1;

        // All registers clear after reset.
        for (int i = 1; i < 32; i++) begin
            read2(reg_addr_t'(i), reg_addr_t'(32 - i));
            check($sformatf("rst_rs1_x%0d", i), rf_if.data_out_rs1, 32'h0);
            check($sformatf("rst_rs2_x%0d", 32 - i), rf_if.data_out_rs2, 32'h0);
        end

        // Walk writes; the next register up must still be untouched.
        for (int i = 1; i < 32; i++) begin
            do_write(reg_addr_t'(i), 32'hA5A5_0000 + 32'(i));
            read2(reg_addr_t'(i), (i < 31) ? reg_addr_t'(i + 1) : 5'd1);
            check($sformatf("wr_rs1_x%0d", i), rf_if.data_out_rs1, 32'hA5A5_0000 + 32'(i));
            check($sformatf("wr_next_x%0d", i), rf_if.data_out_rs2,
                  (i < 31) ? 32'h0 : 32'hA5A5_0001);
        end
        for (int i = 1; i < 32; i++) begin
            read2(reg_addr_t'(i), reg_addr_t'(i));
            check($sformatf("sweep_rs1_x%0d", i), rf_if.data_out_rs1, 32'hA5A5_0000 + 32'(i));
            check($sformatf("sweep_rs2_x%0d", i), rf_if.data_out_rs2, 32'hA5A5_0000 + 32'(i));
        end

        // x0 stays zero, including while a write to it is pending.
        @(negedge rf_if.clk);
        read2(5'd0, 5'd0);
        rf_if.write_en = 1'b1;
        rf_if.rd_addr  = 5'd0;
        rf_if.data_in  = 32'hDEAD_BEEF;
        #1;
        check("x0_pending_rs1", rf_if.data_out_rs1, 32'h0);
        check("x0_pending_rs2", rf_if.data_out_rs2, 32'h0);
        @(posedge rf_if.clk);
        #1;
        rf_if.write_en = 1'b0;
        check("x0_after_rs1", rf_if.data_out_rs1, 32'h0);
        check("x0_after_rs2", rf_if.data_out_rs2, 32'h0);
        @(negedge rf_if.clk);
        check("x0_next_rs1", rf_if.data_out_rs1, 32'h0);

        // Write strobe low: no update.
        @(negedge rf_if.clk);
        rf_if.rd_addr = 5'd9;
        rf_if.data_in = 32'h0BAD_0BAD;
        @(posedge rf_if.clk);
        #1;
        read2(5'd9, 5'd9);
        check("no_wen_x9", rf_if.data_out_rs1, 32'hA5A5_0009);

        // Concurrent reads.
        do_write(5'd5,  32'h1111_1111);
        do_write(5'd10, 32'h2222_2222);
        read2(5'd5, 5'd10);
        check("conc_rs1_x5",  rf_if.data_out_rs1, 32'h1111_1111);
        check("conc_rs2_x10", rf_if.data_out_rs2, 32'h2222_2222);
        read2(5'd10, 5'd10);
        check("same_rs1_x10", rf_if.data_out_rs1, 32'h2222_2222);
        check("same_rs2_x10", rf_if.data_out_rs2, 32'h2222_2222);

        // Write-through bypass before the edge, stored value after it.
        @(negedge rf_if.clk);
        read2(5'd7, 5'd8);
        rf_if.write_en = 1'b1;
        rf_if.rd_addr  = 5'd7;
        rf_if.data_in  = 32'hCAFE_F00D;
        #1;
        check("bypass_rs1_x7", rf_if.data_out_rs1, 32'hCAFE_F00D);
        check("bypass_rs2_x8", rf_if.data_out_rs2, 32'hA5A5_0008);
        @(posedge rf_if.clk);
        #1;
        rf_if.write_en = 1'b0;
        rf_if.data_in  = 32'h0;
        #1;
        check("bypass_stored_x7", rf_if.data_out_rs1, 32'hCAFE_F00D);

        // Asynchronous reset mid-cycle clears immediately.
        do_write(5'd3, 32'h1234_5678);
        read2(5'd3, 5'd5);
        check("pre_rst_x3", rf_if.data_out_rs1, 32'h1234_5678);
        #1;
        rf_if.rst_n = 1'b0;
        #1;
        check("async_rst_x3", rf_if.data_out_rs1, 32'h0);
        check("async_rst_x5", rf_if.data_out_rs2, 32'h0);
        @(negedge rf_if.clk);
        rf_if.rst_n = 1'b1;
        #1;
        check("post_rst_x3", rf_if.data_out_rs1, 32'h0);
        read2(5'd7, 5'd31);
        check("post_rst_x7",  rf_if.data_out_rs1, 32'h0);
        check("post_rst_x31", rf_if.data_out_rs2, 32'h0);

        repeat (2) @(posedge rf_if.clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
